bitop_op_decoder: RTL

- Consumer-side counterpart of the select-controlled AND/OR result stage.
- Accepts (a, b, result) tuples over a valid/ready handshake and recovers the select bit x that produced the result: x=1 means AND, x=0 means OR.
- Classifies every tuple, buffers verdicts in a 2-entry output FIFO, and keeps saturating per-class counters plus a sticky error flag.
- Sits on the monitor/checker path downstream of the AND/OR mux datapath.

---
 rtl/bitop_pkg.sv | 14 +
 rtl/bitop_vfifo2.sv | 68 ++++++
 rtl/bitop_op_decoder.sv | 114 +++++++++++
 3 files changed

// File: rtl/bitop_pkg.sv
// Shared types for the AND/OR select decoder: verdict classes and select encodings.
package bitop_pkg;

    typedef enum logic [1:0] {
        AND   = 2'd0,
        OR    = 2'd1,
        AMBIG = 2'd2,
        BAD   = 2'd3
    } op_class_t;

    localparam logic X_AND = 1'b1;
    localparam logic X_OR  = 1'b0;

endpackage

// File: rtl/bitop_vfifo2.sv
// Two-entry valid/ready FIFO with a registered head, so the head holds the last popped
// word once the FIFO drains.
module bitop_vfifo2 #(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [1:0]    count_q, count_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          push, pop;

    // Ready is derived from occupancy only, so a pop while full does not open a slot.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d  = in_data;
                    count_d = 2'd1;
                end else begin
                    tail_d  = in_data;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            // Push and pop together can only happen at occupancy 1.
            2'b11: head_d = in_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/bitop_op_decoder.sv
// Recovers the AND/OR select bit from (a, b, result) tuples, queues verdicts and keeps
// saturating per-class statistics plus a sticky error flag.
module bitop_op_decoder
    import bitop_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_x,
    output logic [1:0]       out_class,
    output logic [WIDTH-1:0] out_result,
    input  logic             clr_err,
    output logic             err,
    output logic [CNT_W-1:0] cnt_and,
    output logic [CNT_W-1:0] cnt_or,
    output logic [CNT_W-1:0] cnt_ambig,
    output logic [CNT_W-1:0] cnt_bad
);

    localparam int DW = WIDTH + 3;

    logic          and_m, or_m, x;
    op_class_t     cls;
    logic          accept;
    logic          err_q, err_d;
    logic [DW-1:0] fifo_out;

    always_comb begin
        and_m = (in_result == (in_a & in_b));
        or_m  = (in_result == (in_a | in_b));
        cls   = BAD;
        x     = X_OR;
        if (and_m && or_m) begin
            cls = AMBIG;
        end else if (and_m) begin
            cls = AND;
            x   = X_AND;
        end else if (or_m) begin
            cls = OR;
        end
    end

    assign accept = in_valid && in_ready;

    bitop_vfifo2 #(.DW(DW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({x, cls, in_result}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out)
    );

    assign out_x      = fifo_out[DW-1];
    assign out_class  = fifo_out[DW-2:DW-3];
    assign out_result = fifo_out[WIDTH-1:0];

    // One saturating counter per verdict class, indexed by the class encoding.
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (accept && (cls == op_class_t'(gi)) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign cnt_and   = g_cnt[0].cnt_q;
    assign cnt_or    = g_cnt[1].cnt_q;
    assign cnt_ambig = g_cnt[2].cnt_q;
    assign cnt_bad   = g_cnt[3].cnt_q;

    // A BAD accept takes priority over a clear in the same cycle.
    always_comb begin
        err_d = err_q;
        if (accept && (cls == BAD)) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule
